// File: rtl/instr_encoder.sv
// Packs MIPS-Lite instruction fields into 32-bit words and streams them into imem.
// Stops on HALT, on an illegal opcode or immediate, or when the last imem word is written.
module instr_encoder #(
  parameter int DATA    = 32,
  parameter int IMMSIZE = 16,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [DATA-1:0]   in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA-1:0]   imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [5:0]        OP_JR     = 6'h10;
  localparam logic [5:0]        OP_HALT   = 6'h11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              is_r, is_i, is_jr, is_halt, illegal, imm_ok;
  logic              accept, fault, write, full_hit;
  logic [DATA-1:0]   enc_word;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);

  // An immediate is legal when it survives sign-extension from IMMSIZE bits.
  always_comb begin
    is_r     = (in_opcode <= 6'h0A) && !in_opcode[0];
    is_i     = ((in_opcode <= 6'h0B) && in_opcode[0]) || (in_opcode[5:2] == 4'b0011);
    is_jr    = (in_opcode == OP_JR);
    is_halt  = (in_opcode == OP_HALT);
    illegal  = (in_opcode > OP_HALT);
    imm_ok   = (&in_imm[DATA-1:IMMSIZE-1]) || !(|in_imm[DATA-1:IMMSIZE-1]);
    enc_word = '0;
    if (is_r)
      enc_word = {in_opcode, in_rs, in_rt, in_rd, {(DATA-21){1'b0}}};
    else if (is_i)
      enc_word = {in_opcode, in_rs, in_rt, in_imm[IMMSIZE-1:0]};
    else if (is_jr)
      enc_word = {in_opcode, in_rs, {(DATA-11){1'b0}}};
    else if (is_halt)
      enc_word = {in_opcode, {(DATA-6){1'b0}}};
  end

  assign accept   = in_valid && (state == LOAD);
  assign fault    = accept && (illegal || (is_i && !imm_ok));
  assign write    = accept && !fault;
  assign full_hit = write && !is_halt && (wr_ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (fault)                  state_next = ERR;
        else if (write && is_halt)  state_next = DONE;
        else if (full_hit)          state_next = ERR;
      end
      default: if (start) state_next = LOAD;
    endcase
  end

  // Writes are registered: the word appears one cycle after its bundle is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_addr   <= '0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state != LOAD && start) begin
        wr_ptr   <= base_addr;
        count    <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'b00;
        err_addr <= '0;
      end else if (fault) begin
        err      <= 1'b1;
        err_code <= illegal ? 2'b01 : 2'b10;
        err_addr <= wr_ptr;
      end else if (write) begin
        imem_we    <= 1'b1;
        imem_addr  <= wr_ptr;
        imem_wdata <= enc_word;
        count      <= count + 1'b1;
        if (is_halt) begin
          done <= 1'b1;
        end else if (full_hit) begin
          err      <= 1'b1;
          err_code <= 2'b11;
          err_addr <= wr_ptr;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a field-level reference model predicts imem writes
// and terminal status; a negedge monitor pops and compares every write the DUT makes.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int DATA   = 32;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid;
  logic [ADDR_W-1:0] base_addr;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [DATA-1:0]   in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA-1:0]   imem_wdata;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.DATA(DATA), .IMMSIZE(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .err_addr(err_addr), .count(count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA-1:0]   data;
  } wr_t;

  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mstate_t;

  wr_t     exp_q[$];
  int      errors = 0;
  int      checks = 0;
  mstate_t m_state = M_IDLE;
  int      m_ptr, m_count, m_code, m_eaddr;
  bit      m_done, m_err;
  int      writes_seen, writes_expected;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // 0=R, 1=I, 2=JR, 3=HALT, 4=illegal
  function automatic int op_class(input int op);
    if (op > 17)  return 4;
    if (op == 16) return 2;
    if (op == 17) return 3;
    if (op >= 12) return 1;
    return (op % 2 == 0) ? 0 : 1;
  endfunction

  function automatic logic [31:0] model_word(input int op, input int rs, input int rt, input int rd,
                                             input logic [31:0] imm);
    longint w;
    w = longint'(op) * (64'd1 << 26);
    case (op_class(op))
      0: w += rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11);
      1: w += rs * (1 << 21) + rt * (1 << 16) + (imm % 65536);
      2: w += rs * (1 << 21);
      default: ;
    endcase
    return w[31:0];
  endfunction

  function automatic bit imm_in_range(input logic [31:0] imm);
    int s;
    s = $signed(imm);
    return (s >= -32768) && (s <= 32767);
  endfunction

  task automatic modelFault(input int code);
    m_err   = 1;
    m_code  = code;
    m_eaddr = m_ptr;
    m_state = M_ERR;
  endtask

  task automatic modelAccept(input int op, input int rs, input int rt, input int rd, input logic [31:0] imm);
    wr_t w;
    int  cls;
    cls = op_class(op);
    if (cls == 4) modelFault(1);
    else if (cls == 1 && !imm_in_range(imm)) modelFault(2);
    else begin
      w.addr = m_ptr[ADDR_W-1:0];
      w.data = model_word(op, rs, rt, rd, imm);
      exp_q.push_back(w);
      writes_expected++;
      m_count++;
      if (cls == 3) begin
        m_done  = 1;
        m_state = M_DONE;
      end else if (m_ptr == (1 << ADDR_W) - 1) modelFault(3);
      else m_ptr++;
    end
  endtask

  // Drives one bundle for one cycle; called at posedge+1.
  task automatic applyStimulus(input int op, input int rs, input int rt, input int rd, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = op[5:0];
    in_rs     = rs[4:0];
    in_rt     = rt[4:0];
    in_rd     = rd[4:0];
    in_imm    = imm;
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, m_state == M_LOAD});
    if (m_state == M_LOAD) modelAccept(op, rs, rt, rd, imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doStart(input int base);
    start     = 1'b1;
    base_addr = base[ADDR_W-1:0];
    if (m_state != M_LOAD) begin
      m_state = M_LOAD; m_ptr = base; m_count = 0;
      m_done = 0; m_err = 0; m_code = 0; m_eaddr = 0;
      writes_seen = 0; writes_expected = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic endScenario(input string name);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking end of %s", name);
    checkOutput("done", {63'd0, done}, {63'd0, m_done});
    checkOutput("err", {63'd0, err}, {63'd0, m_err});
    checkOutput("err_code", {62'd0, err_code}, 64'(m_code));
    checkOutput("err_addr", {54'd0, err_addr}, 64'(m_eaddr));
    checkOutput("count", {53'd0, count}, 64'(m_count));
    checkOutput("busy", {63'd0, busy}, {63'd0, m_state == M_LOAD});
    checkOutput("pending_writes", 64'(exp_q.size()), 64'd0);
    checkOutput("write_cycles", 64'(writes_seen), 64'(writes_expected));
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 9))
      0: return 32'd32767;
      1: return 32'hFFFF8000;
      2: return 32'd32768;
      3: return 32'hFFFF7FFF;
      4: return $urandom;
      default: return 32'($urandom_range(0, 65535)) - 32'd32768;
    endcase
  endfunction

  always @(negedge clk) begin
    if (imem_we) begin
      wr_t w;
      writes_seen++;
      if (exp_q.size() == 0) checkOutput("unexpected_write", 64'd1, 64'd0);
      else begin
        w = exp_q.pop_front();
        checkOutput("imem_addr", {54'd0, imem_addr}, {54'd0, w.addr});
        checkOutput("imem_wdata", {32'd0, imem_wdata}, {32'd0, w.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; base_addr = '0;
    in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {imem_we, busy, done, err, in_ready, err_code, err_addr, count, imem_addr},
                64'd0);
    checkOutput("reset_wdata", {32'd0, imem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd0);

    // ADDI then HALT from base 0
    doStart(0);
    applyStimulus(1, 1, 2, 0, 32'hFFFFFFFB);
    applyStimulus(17, 0, 0, 0, 32'h0);
    endScenario("addi_halt");

    // R-type ADD at base 0x10
    doStart('h10);
    applyStimulus(0, 3, 4, 5, 32'hDEADBEEF);
    applyStimulus(17, 0, 0, 0, 32'h0);
    endScenario("add_rtype");

    // ORI immediate boundary
    doStart('h20);
    applyStimulus(13, 2, 3, 0, 32'd32767);
    applyStimulus(13, 2, 3, 0, 32'd32768);
    applyStimulus(13, 2, 3, 0, 32'd1);
    endScenario("ori_range");

    // Illegal opcode wins over bad immediate, then restart clears it
    doStart('h30);
    applyStimulus(63, 1, 1, 1, 32'h12345678);
    endScenario("illegal_op");
    doStart('h40);
    applyStimulus(16, 7, 0, 0, 32'h12345678);
    applyStimulus(17, 0, 0, 0, 32'h0);
    endScenario("restart_after_err");

    // Memory full at the top of imem
    doStart('h3FE);
    applyStimulus(1, 1, 1, 0, 32'd5);
    applyStimulus(0, 1, 2, 3, 32'd0);
    applyStimulus(1, 1, 1, 0, 32'd6);
    endScenario("mem_full");

    // Randomized loads
    for (int r = 0; r < 12; r++) begin
      doStart((r % 4 == 3) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 1000)));
      for (int i = 0; i < 20 && m_state == M_LOAD; i++) begin
        int op;
        op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(18, 63)) : int'($urandom_range(0, 17));
        applyStimulus(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), pick_imm());
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      if (m_state == M_LOAD) applyStimulus(17, 0, 0, 0, 32'h0);
      endScenario("random_load");
    end

    // Reset during a back-to-back stream
    doStart('h100);
    applyStimulus(1, 1, 2, 0, 32'd10);
    applyStimulus(0, 4, 5, 6, 32'd0);
    applyStimulus(1, 3, 3, 0, 32'd11);
    in_valid = 1'b1; in_opcode = 6'd1; in_imm = 32'd12;
    rst_n = 1'b0;
    m_state = M_IDLE;
    @(posedge clk); #1;
    checkOutput("rst_mid_outputs", {imem_we, busy, done, err, in_ready, err_code, err_addr, count, imem_addr},
                64'd0);
    checkOutput("rst_mid_pending", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    writes_seen = 0; writes_expected = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("post_reset_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_writes", 64'(writes_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's decode-side immediate generation: packs MIPS-Lite instruction fields plus a full-width immediate into 32-bit instruction words and streams them into instruction memory before a run.
- Sits between the testbench/host loader and the imem write port.
- Checks opcode legality and 16-bit signed immediate range.
- Stops after HALT, on error, or when the memory is full.

Parameters:
- DATA, 32, instruction/immediate width.
- IMMSIZE, 16, encoded immediate field width.
- ADDR_W, 10, imem word-address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  pulse; begins a load at base_addr.
- base_addr  input  ADDR_W  first word address.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder accepts the bundle this cycle.
- in_opcode  input  6  opcode.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  DATA  un-encoded immediate value.
- imem_we  output  1  write strobe.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  DATA  encoded instruction.
- busy  output  1  load in progress.
- done  output  1  sticky; HALT written.
- err  output  1  sticky; load aborted.
- err_code  output  2  01 illegal opcode, 10 immediate out of range, 11 memory full.
- err_addr  output  ADDR_W  address of the offending word.
- count  output  ADDR_W+1  words written this load.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0.
- States:
  - IDLE: in_ready=0; start -> LOAD, wr_ptr<=base_addr, count<=0, done/err/err_code/err_addr cleared.
  - LOAD: in_ready=1; busy=1.
  - DONE: terminal until start.
  - ERR: terminal until start.
- start in DONE/ERR behaves as in IDLE. start in LOAD is ignored.
- Accept = in_valid && in_ready. On accept, the registered write appears the next cycle: imem_we=1 for exactly one cycle, with imem_addr=wr_ptr and imem_wdata=encoded word. Then wr_ptr and count increment. Latency is 1 cycle, throughput 1 word/cycle.
- Opcode classes:
  - R-type {000000,000010,000100,000110,001000,001010}: {op,rs,rt,rd,11'b0}.
  - I-type {000001,000011,000101,000111,001001,001011,001100,001101,001110,001111}: {op,rs,rt,in_imm[15:0]}.
  - JR 010000: {op,rs,21'b0}.
  - HALT 010001: {op,26'b0}.
- Immediate legality (I-type only): in_imm[DATA-1:IMMSIZE-1] all equal. Thus -32768..32767 are legal. Must round-trip through sign-extension.
- R/JR/HALT ignore in_imm; out-of-range values there are not errors.
- Illegal opcode (>010001) or bad immediate: no write. Next cycle err=1, err_code set, err_addr=wr_ptr, state ERR. If both conditions apply, illegal opcode wins.
- HALT accepted: HALT is written, then state DONE, done=1.
- Memory full: wr_ptr=2^ADDR_W-1 and that word is written without being HALT. Next cycle err_code=11, err_addr=that address, state ERR. No wrap to 0.
- in_ready drops to 0 in the cycle after any terminating accept, because the state has left LOAD.
- Reset mid-load aborts immediately. No imem_we the cycle after reset is asserted.
- count saturates naturally at 2^ADDR_W and never exceeds it.

Test Plan:
- Load from base 0: ADDI rs=1 rt=2 imm=-5, then HALT -> word 0=0x0422FFFB, word 1=0x44000000; done=1; count=2; imem_we high exactly 2 cycles.
- R-type ADD rs=3 rt=4 rd=5 at base 0x10 -> imem_addr 0x010, imem_wdata 0x00642800.
- ORI imm=32767 accepted (0x7FFF field). Next bundle ORI imm=32768 -> no write, err=1, err_code=10, err_addr=base+1, in_ready=0 afterwards.
- Opcode 6'b111111 with in_imm=0x12345678 -> err_code=01 (opcode priority). A following start clears err and reloads from base.
- Base=0x3FE: two non-HALT words written at 0x3FE and 0x3FF -> err_code=11, err_addr=0x3FF, count=2, no write to 0x000.
- rst_n low during back-to-back stream -> outputs 0 next cycle, in_ready=0 until the next start.
